// File: rtl/bf_prog_loader_if.sv
// Program-load handshake and program RAM write bus between the loader and cpu_core.
// The loader is the master: it drives the write strobe, address and opcode,
// and the busy/done status, while cpu_core drives the arm pulse.
interface bf_prog_loader_if #(
    parameter int ADDR_W = 12
);
    logic              start;
    logic              busy;
    logic              done;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [3:0]        prog_wdata;

    modport master (
        input  start,
        output busy,
        output done,
        output prog_we,
        output prog_addr,
        output prog_wdata
    );

    modport slave (
        output start,
        input  busy,
        input  done,
        input  prog_we,
        input  prog_addr,
        input  prog_wdata
    );
endinterface

// File: rtl/bf_prog_loader.sv
// Brainfuck program loader: receives a program over UART 8N1, drops
// non-command bytes, encodes the eight commands to opcodes, tracks bracket
// nesting and writes the opcode stream plus a trailing END opcode into
// program RAM.
module bf_prog_loader #(
    parameter int          CLK_HZ   = 12000000,
    parameter int          BAUD     = 115200,
    parameter int          ADDR_W   = 12,
    parameter logic [7:0]  END_CHAR = 8'h00,
    parameter int          DEPTH_W  = 8
) (
    input  logic              CLK,
    input  logic              resetn,
    input  logic              rx,
    bf_prog_loader_if.master  bus,
    output logic [ADDR_W-1:0] prog_len,
    output logic              err_bracket,
    output logic              err_overflow,
    output logic              err_frame
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0]  DIV_M1    = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  HALF_M1   = CNT_W'(DIV / 2 - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};
    localparam logic [3:0] OP_END  = 4'd8;
    localparam logic [3:0] OP_NONE = 4'd15;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {IDLE, RECV, WR_END, DONE} state_t;

    // Map a received character to its opcode; OP_NONE marks a non-command byte.
    function automatic logic [3:0] encode_cmd(input logic [7:0] c);
        logic [3:0] op;
        op = OP_NONE;
        case (c)
            8'h3E: op = 4'd0;
            8'h3C: op = 4'd1;
            8'h2B: op = 4'd2;
            8'h2D: op = 4'd3;
            8'h2E: op = 4'd4;
            8'h2C: op = 4'd5;
            8'h5B: op = 4'd6;
            8'h5D: op = 4'd7;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

    logic rx_meta, rx_sync, rx_prev;

    rx_state_t        rx_state, rx_state_nx;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_nx;
    logic [2:0]       bit_idx, bit_idx_nx;
    logic [7:0]       rx_shift, rx_shift_nx;
    logic             rx_valid, rx_valid_nx;
    logic             rx_ferr, rx_ferr_nx;

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  prog_len_nx;
    logic [DEPTH_W-1:0] depth, depth_nx;
    logic               err_bracket_nx, err_overflow_nx, err_frame_nx;
    logic               busy_nx, done_nx, we_nx;
    logic [ADDR_W-1:0]  addr_nx;
    logic [3:0]         wdata_nx;
    logic [3:0]         rx_op;

    // Two-flop synchroniser on the asynchronous rx line, plus one delayed copy
    // for falling-edge detection; all reset to the idle-high line level.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // UART receiver state and datapath registers.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_state <= rx_state_nx;
            rx_cnt   <= rx_cnt_nx;
            bit_idx  <= bit_idx_nx;
            rx_shift <= rx_shift_nx;
            rx_valid <= rx_valid_nx;
            rx_ferr  <= rx_ferr_nx;
        end
    end

    // UART receiver: validate the start bit at mid-bit, sample eight data bits
    // LSB first, then check the stop bit; the returned idle state needs a fresh
    // falling edge, so a low stop bit cannot retrigger a start on its own.
    always_comb begin
        rx_state_nx = rx_state;
        rx_cnt_nx   = rx_cnt;
        bit_idx_nx  = bit_idx;
        rx_shift_nx = rx_shift;
        rx_valid_nx = 1'b0;
        rx_ferr_nx  = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_state_nx = R_START;
                    rx_cnt_nx   = '0;
                end
            end
            R_START: begin
                if (rx_cnt == HALF_M1) begin
                    rx_cnt_nx   = '0;
                    bit_idx_nx  = '0;
                    rx_state_nx = rx_sync ? R_IDLE : R_DATA;
                end else begin
                    rx_cnt_nx = rx_cnt + CNT_W'(1);
                end
            end
            R_DATA: begin
                if (rx_cnt == DIV_M1) begin
                    rx_cnt_nx   = '0;
                    rx_shift_nx = {rx_sync, rx_shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        rx_state_nx = R_STOP;
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end else begin
                    rx_cnt_nx = rx_cnt + CNT_W'(1);
                end
            end
            R_STOP: begin
                if (rx_cnt == DIV_M1) begin
                    rx_cnt_nx   = '0;
                    rx_state_nx = R_IDLE;
                    if (rx_sync) begin
                        rx_valid_nx = 1'b1;
                    end else begin
                        rx_ferr_nx = 1'b1;
                    end
                end else begin
                    rx_cnt_nx = rx_cnt + CNT_W'(1);
                end
            end
            default: rx_state_nx = R_IDLE;
        endcase
    end

    assign rx_op = encode_cmd(rx_shift);

    // Loader state, counters, sticky errors and the registered write bus.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            prog_len       <= '0;
            depth          <= '0;
            err_bracket    <= 1'b0;
            err_overflow   <= 1'b0;
            err_frame      <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.prog_we    <= 1'b0;
            bus.prog_addr  <= '0;
            bus.prog_wdata <= '0;
        end else begin
            state          <= state_nx;
            prog_len       <= prog_len_nx;
            depth          <= depth_nx;
            err_bracket    <= err_bracket_nx;
            err_overflow   <= err_overflow_nx;
            err_frame      <= err_frame_nx;
            bus.busy       <= busy_nx;
            bus.done       <= done_nx;
            bus.prog_we    <= we_nx;
            bus.prog_addr  <= addr_nx;
            bus.prog_wdata <= wdata_nx;
        end
    end

    // Loader control: arm on start, turn each received command into one write
    // the following cycle, and close the upload with the END write either on
    // the terminator byte or when the next command would land on the slot
    // reserved for END.
    always_comb begin
        state_nx        = state;
        prog_len_nx     = prog_len;
        depth_nx        = depth;
        err_bracket_nx  = err_bracket;
        err_overflow_nx = err_overflow;
        err_frame_nx    = err_frame | (rx_ferr & bus.busy);
        busy_nx         = bus.busy;
        done_nx         = 1'b0;
        we_nx           = 1'b0;
        addr_nx         = bus.prog_addr;
        wdata_nx        = bus.prog_wdata;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    prog_len_nx     = '0;
                    depth_nx        = '0;
                    err_bracket_nx  = 1'b0;
                    err_overflow_nx = 1'b0;
                    err_frame_nx    = 1'b0;
                    busy_nx         = 1'b1;
                    state_nx        = RECV;
                end
            end
            RECV: begin
                if (rx_valid) begin
                    if (rx_shift == END_CHAR) begin
                        we_nx    = 1'b1;
                        addr_nx  = prog_len;
                        wdata_nx = OP_END;
                        state_nx = WR_END;
                    end else if (rx_op != OP_NONE) begin
                        if (prog_len == LAST_ADDR) begin
                            err_overflow_nx = 1'b1;
                            we_nx           = 1'b1;
                            addr_nx         = prog_len;
                            wdata_nx        = OP_END;
                            state_nx        = WR_END;
                        end else begin
                            we_nx       = 1'b1;
                            addr_nx     = prog_len;
                            wdata_nx    = rx_op;
                            prog_len_nx = prog_len + ADDR_W'(1);
                            if (rx_op == 4'd6) begin
                                if (depth == DEPTH_MAX) begin
                                    err_bracket_nx = 1'b1;
                                end else begin
                                    depth_nx = depth + DEPTH_W'(1);
                                end
                            end else if (rx_op == 4'd7) begin
                                if (depth == '0) begin
                                    err_bracket_nx = 1'b1;
                                end else begin
                                    depth_nx = depth - DEPTH_W'(1);
                                end
                            end
                        end
                    end
                end
            end
            WR_END: begin
                if (depth != '0) begin
                    err_bracket_nx = 1'b1;
                end
                busy_nx  = 1'b0;
                done_nx  = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
